// File: rtl/msp_frame_tx.sv
// MSP response framer: latches one response and streams it as an MSP v1 ($M, XOR) or v2 ($X, CRC8 DVB-S2) frame.
// Optional v2 framing is built only when MSP_V2_FRAMING_EN is defined; otherwise every frame is v1.
module msp_frame_tx #(
  parameter int MAX_PAYLOAD = 16,
  parameter int LEN_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              resp_cmd,
  input  logic [LEN_W-1:0]         resp_len,
  input  logic [MAX_PAYLOAD*8-1:0] resp_payload,
  input  logic                     resp_v2,
  input  logic                     resp_err,
  input  logic                     resp_valid,
  output logic                     resp_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     len_clamped,
  output logic [3:0]               state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // source holds its data stable while valid is high and ready is low.

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_VER, S_DIR, S_FLAG, S_CMD, S_CMDH, S_LEN, S_LENH, S_DATA, S_CRC
  } state_t;

  state_t                   state, state_nx;
  logic [15:0]              cmd_q, len_q, idx;
  logic [MAX_PAYLOAD*8-1:0] payload_q;
  logic                     err_q, v2_q;
  logic [7:0]               crc_q, crc_nx;
  logic                     capture, accept, covered, len_zero, last_data, clamp;
  logic [15:0]              len_eff;

  assign resp_ready  = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign tx_valid    = (state != S_IDLE);
  assign state_dbg   = state;
  assign capture     = resp_valid && resp_ready;
  assign accept      = tx_valid && tx_ready;
  assign clamp       = 32'(resp_len) > MAX_PAYLOAD;
  assign len_eff     = clamp ? 16'(MAX_PAYLOAD) : 16'(resp_len);
  assign len_clamped = capture && clamp;
  assign frame_done  = (state == S_CRC) && tx_ready;
  assign len_zero    = (len_q == 16'd0);
  assign last_data   = ((idx + 16'd1) == len_q);
  assign covered     = state inside {S_FLAG, S_CMD, S_CMDH, S_LEN, S_LENH, S_DATA};

`ifdef MSP_V2_FRAMING_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'hD5) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)          v2_q <= 1'b0;
    else if (capture) v2_q <= resp_v2;
  end

  assign crc_nx = v2_q ? crc8_step(crc_q, tx_data) : (crc_q ^ tx_data);
`else
  logic unused_v2;
  assign unused_v2 = resp_v2;
  assign v2_q      = 1'b0;
  assign crc_nx    = crc_q ^ tx_data;
`endif

  always_comb begin
    tx_data = 8'h00;
    case (state)
      S_SOF:  tx_data = 8'h24;
      S_VER:  tx_data = v2_q ? 8'h58 : 8'h4D;
      S_DIR:  tx_data = err_q ? 8'h21 : 8'h3E;
      S_FLAG: tx_data = 8'h00;
      S_CMD:  tx_data = cmd_q[7:0];
      S_CMDH: tx_data = cmd_q[15:8];
      S_LEN:  tx_data = len_q[7:0];
      S_LENH: tx_data = len_q[15:8];
      S_DATA: tx_data = payload_q[8*idx +: 8];
      S_CRC:  tx_data = crc_q;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (resp_valid) state_nx = S_SOF;
      S_SOF:  if (tx_ready) state_nx = S_VER;
      S_VER:  if (tx_ready) state_nx = S_DIR;
      S_DIR:  if (tx_ready) state_nx = v2_q ? S_FLAG : S_LEN;
      S_LEN:  if (tx_ready) state_nx = v2_q ? S_LENH : S_CMD;
      S_CMD:  if (tx_ready) state_nx = v2_q ? S_CMDH : (len_zero ? S_CRC : S_DATA);
`ifdef MSP_V2_FRAMING_EN
      S_FLAG: if (tx_ready) state_nx = S_CMD;
      S_CMDH: if (tx_ready) state_nx = S_LEN;
      S_LENH: if (tx_ready) state_nx = len_zero ? S_CRC : S_DATA;
`endif
      S_DATA: if (tx_ready) state_nx = last_data ? S_CRC : S_DATA;
      S_CRC:  if (tx_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      payload_q <= '0;
      err_q     <= 1'b0;
      idx       <= '0;
      crc_q     <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        cmd_q     <= resp_cmd;
        len_q     <= len_eff;
        payload_q <= resp_payload;
        err_q     <= resp_err;
        idx       <= '0;
        crc_q     <= '0;
      end else if (accept) begin
        if (covered) crc_q <= crc_nx;
        if (state == S_DATA) idx <= idx + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_msp_frame_tx.sv
// Self-checking bench for msp_frame_tx: frame-level reference model, per-cycle compare process,
// literal frame checks, backpressure, clamping, mid-frame reset and randomized traffic.
module tb_msp_frame_tx;
  localparam int MP    = 16;
  localparam int LEN_W = 8;
`ifdef MSP_V2_FRAMING_EN
  localparam bit V2_EN = 1'b1;
`else
  localparam bit V2_EN = 1'b0;
`endif

  logic              clk, rst;
  logic [15:0]       resp_cmd;
  logic [LEN_W-1:0]  resp_len;
  logic [MP*8-1:0]   resp_payload;
  logic              resp_v2, resp_err, resp_valid, resp_ready;
  logic [7:0]        tx_data;
  logic              tx_valid, tx_ready, busy, frame_done, len_clamped;
  logic [3:0]        state_dbg;

  msp_frame_tx #(.MAX_PAYLOAD(MP), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .resp_cmd(resp_cmd), .resp_len(resp_len),
    .resp_payload(resp_payload), .resp_v2(resp_v2), .resp_err(resp_err),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done), .len_clamped(len_clamped), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int rdy_mode = 0;
  logic [7:0] exp_q[$];
  bit         last_q[$];
  logic [7:0] rx_log[$];
  logic [7:0] frm[$];
  logic [7:0] lit[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference model: whole frame from the framing rules
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ 8'hD5) : (r << 1);
    return r;
  endfunction

  function automatic void build_frame(input logic [15:0] cmd, input int len,
                                      input logic [MP*8-1:0] pl, input bit v2, input bit err);
    logic [7:0] body[$];
    logic [7:0] chk;
    int l;
    bit use_v2;
    l = (len > MP) ? MP : len;
    use_v2 = V2_EN && v2;
    body.delete();
    if (use_v2) begin
      body.push_back(8'h00);
      body.push_back(cmd[7:0]);
      body.push_back(cmd[15:8]);
      body.push_back(8'(l));
      body.push_back(8'(l >> 8));
    end else begin
      body.push_back(8'(l));
      body.push_back(cmd[7:0]);
    end
    for (int k = 0; k < l; k++) body.push_back(pl[8*k +: 8]);
    chk = 8'h00;
    foreach (body[k]) chk = use_v2 ? crc8(chk, body[k]) : (chk ^ body[k]);
    frm.delete();
    frm.push_back(8'h24);
    frm.push_back(use_v2 ? 8'h58 : 8'h4D);
    frm.push_back(err ? 8'h21 : 8'h3E);
    foreach (body[k]) frm.push_back(body[k]);
    frm.push_back(chk);
  endfunction

  // driver tasks
  task automatic send_resp(input logic [15:0] cmd, input int len, input logic [MP*8-1:0] pl,
                           input bit v2, input bit err);
    int n;
    @(posedge clk); #1;
    resp_cmd = cmd; resp_len = LEN_W'(len); resp_payload = pl;
    resp_v2 = v2; resp_err = err; resp_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!resp_ready && n < 2000) begin @(negedge clk); n++; end
    check("resp_ready_wait", 32'(resp_ready), 32'd1);
    check("len_clamped", 32'(len_clamped), 32'(len > MP));
    build_frame(cmd, len, pl, v2, err);
    foreach (frm[k]) begin
      exp_q.push_back(frm[k]);
      last_q.push_back(k == frm.size() - 1);
    end
    @(posedge clk); #1;
    resp_valid = 1'b0;
    check("ready_drop", 32'({resp_ready, busy}), 32'b01);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin @(posedge clk); #1; n++; end
    check("idle_timeout", 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  task automatic cmp_log(input string name);
    check({name, "_len"}, 32'(rx_log.size()), 32'(lit.size()));
    foreach (lit[k]) if (k < rx_log.size()) check(name, 32'(rx_log[k]), 32'(lit[k]));
  endtask

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ~tx_ready;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // scoreboard / compare process, sampled on the falling edge
  bit         prev_stall = 0;
  bit         prev_mid = 0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    bit lst;
    if (rst) begin
      exp_q.delete(); last_q.delete();
      prev_stall = 0; prev_mid = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
      end
      if (prev_mid) check("no_bubble", 32'(tx_valid), 32'd1);
      prev_mid = 0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          lst = last_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(e));
          check("frame_done", 32'(frame_done), 32'(lst));
          prev_mid = !lst;
        end
        rx_log.push_back(tx_data);
        acc_cnt++;
      end else begin
        check("frame_done_idle", 32'(frame_done), 32'd0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    logic [MP*8-1:0] pl;
    int n;
    rst = 1'b1;
    resp_cmd = '0; resp_len = '0; resp_payload = '0;
    resp_v2 = 0; resp_err = 0; resp_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 32'(resp_ready), 32'd1);
    check("rst_tx", 32'({tx_valid, tx_data}), 32'd0);
    check("rst_flags", 32'({busy, frame_done, len_clamped}), 32'd0);

    // test 1: v1 empty frame, N consecutive clks
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    rx_log.delete();
    send_resp(16'h0064, 0, '0, 1'b0, 1'b0);
    n = 1;
    @(negedge clk);
    while (!frame_done && n < 50) begin @(negedge clk); n++; end
    check("t1_done_cycle", 32'(n), 32'd6);
    wait_idle();
    lit = '{8'h24, 8'h4D, 8'h3E, 8'h00, 8'h64, 8'h64};
    cmp_log("t1");

    // test 2: v1 with payload
    pl = '0; pl[7:0] = 8'h11; pl[15:8] = 8'h22;
    rx_log.delete();
    send_resp(16'h0065, 2, pl, 1'b0, 1'b0);
    wait_idle();
    lit = '{8'h24, 8'h4D, 8'h3E, 8'h02, 8'h65, 8'h11, 8'h22, 8'h54};
    cmp_log("t2");

    // test 3: v2 error frame (falls back to v1 when v2 framing is not built)
    rx_log.delete();
    send_resp(16'h0064, 0, '0, 1'b1, 1'b1);
    wait_idle();
`ifdef MSP_V2_FRAMING_EN
    lit = '{8'h24, 8'h58, 8'h21, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h8F};
`else
    lit = '{8'h24, 8'h4D, 8'h21, 8'h00, 8'h64, 8'h64};
`endif
    cmp_log("t3");

    // test 4: backpressure on test 2
    rdy_mode = 1;
    rx_log.delete();
    send_resp(16'h0065, 2, pl, 1'b0, 1'b0);
    wait_idle();
    lit = '{8'h24, 8'h4D, 8'h3E, 8'h02, 8'h65, 8'h11, 8'h22, 8'h54};
    cmp_log("t4");

    // test 5: length clamp
    rdy_mode = 0;
    for (int k = 0; k < MP; k++) pl[8*k +: 8] = 8'(k + 1);
    rx_log.delete();
    send_resp(16'h0033, 20, pl, 1'b0, 1'b0);
    wait_idle();
    check("t5_size", 32'(rx_log.size()), 32'd22);
    if (rx_log.size() > 3) check("t5_len_byte", 32'(rx_log[3]), 32'h10);

    // test 6: reset after third accepted byte, then a clean frame
    acc_cnt = 0;
    send_resp(16'h0042, 4, pl, 1'b1, 1'b0);
    n = 0;
    while (acc_cnt < 3 && n < 100) begin @(posedge clk); #1; n++; end
    check("t6_three_bytes", 32'(acc_cnt), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_abort", 32'({tx_valid, busy, resp_ready}), 32'b001);
    rst = 1'b0;
    rx_log.delete();
    send_resp(16'h0064, 0, '0, 1'b0, 1'b0);
    wait_idle();
    lit = '{8'h24, 8'h4D, 8'h3E, 8'h00, 8'h64, 8'h64};
    cmp_log("t6");

    // randomized back-to-back traffic
    for (int t = 0; t < 40; t++) begin
      rdy_mode = $urandom_range(0, 2);
      for (int k = 0; k < MP; k++) pl[8*k +: 8] = 8'($urandom_range(0, 255));
      send_resp(16'($urandom_range(0, 65535)), $urandom_range(0, 20), pl,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
